// File: rtl/red_iterativa_secuencial.sv
// Bit-serial comparator network: one cell evaluation per clock, LSB-first or MSB-first.
// Latency: done pulses K clocks after the edge that accepts start.
// Backpressure: start is ignored while busy; accepted in IDLE or during the done cycle.
module red_iterativa_secuencial #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dir,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] N,
    output logic         Z,
    output logic         EQ
);

    localparam int IW = $clog2(K);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [1:0] {C_EQ, C_GT, C_LT} cell_t;

    state_t        state_q, state_d;
    cell_t         s_q, s_d;
    cell_t         c_bit, s_nxt;
    logic [K-1:0]  a_q, a_d, b_q, b_d, n_q, n_d;
    logic          dir_q, dir_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          z_q, z_d, eq_q, eq_d;
    logic          last_bit;
    logic          accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= C_EQ;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            z_q     <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        c_bit = C_EQ;
        if (a_q[idx_q] && !b_q[idx_q]) begin
            c_bit = C_GT;
        end else if (!a_q[idx_q] && b_q[idx_q]) begin
            c_bit = C_LT;
        end

        // LSB-first: later (more significant) differences win; MSB-first: first difference sticks.
        s_nxt = s_q;
        if (dir_q) begin
            if (s_q == C_EQ) begin
                s_nxt = c_bit;
            end
        end else begin
            if (c_bit != C_EQ) begin
                s_nxt = c_bit;
            end
        end

        last_bit = dir_q ? (idx_q == '0) : (idx_q == IW'(K - 1));
        accept   = start && (state_q != ST_RUN);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        z_d     = z_q;
        eq_d    = eq_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    dir_d   = dir;
                    n_d     = '0;
                    s_d     = C_EQ;
                    idx_d   = dir ? IW'(K - 1) : '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d        = s_nxt;
                n_d[idx_q] = (s_nxt == C_GT);
                if (last_bit) begin
                    z_d     = (s_nxt == C_GT);
                    eq_d    = (s_nxt == C_EQ);
                    state_d = ST_DONE;
                end else begin
                    idx_d = dir_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign N    = n_q;
    assign Z    = z_q;
    assign EQ   = eq_q;

endmodule

// File: tb/tb_red_iterativa_secuencial.sv
// Directed bench for red_iterativa_secuencial: K=4 and K=8 instances, hand-computed results.
module tb_red_iterativa_secuencial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, dir4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, z4, eq4;
    logic [3:0] n4;
    logic       start8 = 1'b0, dir8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, z8, eq8;
    logic [7:0] n8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    red_iterativa_secuencial #(.K(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dir(dir4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .N(n4), .Z(z4), .EQ(eq4)
    );

    red_iterativa_secuencial #(.K(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dir(dir8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .N(n8), .Z(z8), .EQ(eq8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cmp4(input string tag, input logic d, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] en, input logic ez, input logic eeq);
        int lat;
        lat = 0;
        @(negedge clk);
        start4 = 1'b1; dir4 = d; a4 = a; b4 = b;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done4) lat = i;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_N"}, n4, en);
        chk({tag, "_Z"}, z4, ez);
        chk({tag, "_EQ"}, eq4, eeq);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {busy4, done4}, 2'b00);
    endtask

    initial begin
        int first_d, second_d, seen;

        #2;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_N", n4, 0);
        chk("rst_ZEQ", {z4, eq4}, 2'b00);
        @(negedge clk); rst_n = 1'b1;

        cmp4("r2l",    1'b0, 4'b1010, 4'b1001, 4'b1110, 1'b1, 1'b0);
        cmp4("l2r",    1'b1, 4'b1010, 4'b1001, 4'b0011, 1'b1, 1'b0);
        cmp4("l2r_lt", 1'b1, 4'b0011, 4'b0101, 4'b0000, 1'b0, 1'b0);
        cmp4("eq_r2l", 1'b0, 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b1);
        cmp4("eq_l2r", 1'b1, 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b1);

        // start pulsed mid-run with different operands must be ignored
        @(negedge clk);
        start4 = 1'b1; dir4 = 1'b0; a4 = 4'b1010; b4 = 4'b1001;
        @(posedge clk); #1;
        start4 = 1'b0;
        seen = 0;
        for (int i = 1; i <= 4; i++) begin
            if (busy4) seen++;
            if (i == 1) begin
                start4 = 1'b1; dir4 = 1'b1; a4 = 4'b0000; b4 = 4'b1111;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("ign_busy4", seen, 4);
        chk("ign_done", done4, 1);
        chk("ign_N", n4, 4'b1110);
        chk("ign_Z", z4, 1);
        @(posedge clk); #1;

        // start held through DONE: back-to-back, new operands latched at the DONE edge
        @(negedge clk);
        start4 = 1'b1; dir4 = 1'b0; a4 = 4'b1010; b4 = 4'b1001;
        @(posedge clk); #1;
        first_d = 0; second_d = 0;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                dir4 = 1'b1; a4 = 4'b0110; b4 = 4'b0110;
            end
            if (i == 6) start4 = 1'b0;
            if (done4) begin
                if (first_d == 0) begin
                    first_d = i;
                    chk("b2b_N1", n4, 4'b1110);
                    chk("b2b_Z1", z4, 1);
                end else if (second_d == 0) begin
                    second_d = i;
                    chk("b2b_N2", n4, 4'b0000);
                    chk("b2b_EQ2", {z4, eq4}, 2'b01);
                end
            end
            if (i == 5) chk("b2b_noidle", busy4, 1);
            if (i == 11) chk("b2b_end", {busy4, done4}, 2'b00);
        end
        chk("b2b_first", first_d, 4);
        chk("b2b_gap", second_d - first_d, 5);

        // reset asserted for one cycle across the 2nd RUN edge
        @(negedge clk);
        start4 = 1'b1; dir4 = 1'b0; a4 = 4'b1010; b4 = 4'b1001;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("rmid_busy", busy4, 0);
        chk("rmid_N", n4, 0);
        chk("rmid_ZEQ", {z4, eq4}, 2'b00);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) seen++;
        end
        chk("rmid_nodone", seen, 0);
        cmp4("after_rst", 1'b0, 4'b1010, 4'b1001, 4'b1110, 1'b1, 1'b0);

        // K=8 instance
        @(negedge clk);
        start8 = 1'b1; dir8 = 1'b0; a8 = 8'h80; b8 = 8'h7F;
        @(posedge clk); #1;
        start8 = 1'b0;
        seen = 0;
        for (int i = 1; i <= 30 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (done8) seen = i;
        end
        chk("k8_lat", seen, 8);
        chk("k8_N", n8, 8'h80);
        chk("k8_ZEQ", {z8, eq8}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
